// File: rtl/gcd_arbiter_if.sv
// Request/response channel bundle between NUM_REQ requesters and gcd_arbiter.
// master: requester side; slave: arbiter side.
interface gcd_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 2
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_value1;
  logic [NUM_REQ*WIDTH-1:0] req_value2;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [WIDTH-1:0]         resp_gcd;

  modport master (
    output req_valid, req_value1, req_value2, resp_ready,
    input  req_ready, resp_valid, resp_gcd
  );

  modport slave (
    input  req_valid, req_value1, req_value2, resp_ready,
    output req_ready, resp_valid, resp_gcd
  );

endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter/sequencer sharing one GCD unit between NUM_REQ requesters.
// One operation in flight: IDLE -> LOAD -> WAIT -> RESP, or IDLE -> RESP when an
// operand is zero (the GCD never terminates for x=0, y!=0, so it is bypassed).
// Optional WAIT timeout with resp_err output: define GCD_ARB_TIMEOUT_EN.
module gcd_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 2
`ifdef GCD_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic             clock,
  input  logic             reset_n,
  gcd_arbiter_if.slave     req_bus,
  output logic             busy,
  output logic [WIDTH-1:0] gcd_value1,
  output logic [WIDTH-1:0] gcd_value2,
  output logic             gcd_loadingValues,
  input  logic [WIDTH-1:0] gcd_outputGCD,
  input  logic             gcd_outputValid
`ifdef GCD_ARB_TIMEOUT_EN
  ,
  output logic             resp_err
`endif
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef GCD_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic [WIDTH-1:0] grant_v1;
  logic [WIDTH-1:0] grant_v2;
`ifdef GCD_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;
`endif

  // First valid requester at or after rr_ptr, with wrap; descending scan so the closest wins.
  always_comb begin
    logic [IDX_W:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (req_bus.req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign grant_v1 = req_bus.req_value1[int'(grant_idx)*WIDTH +: WIDTH];
  assign grant_v2 = req_bus.req_value2[int'(grant_idx)*WIDTH +: WIDTH];

  // Combinational accept: only in IDLE and never while reset is asserted.
  always_comb begin
    req_bus.req_ready = '0;
    if (reset_n && (state == S_IDLE) && grant_found) req_bus.req_ready[grant_idx] = 1'b1;
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      rr_ptr             <= '0;
      owner              <= '0;
      busy               <= 1'b0;
      gcd_value1         <= '0;
      gcd_value2         <= '0;
      gcd_loadingValues  <= 1'b0;
      req_bus.resp_valid <= '0;
      req_bus.resp_gcd   <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
      wait_cnt           <= '0;
      resp_err           <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            owner  <= grant_idx;
            rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            busy   <= 1'b1;
            if ((grant_v1 == '0) || (grant_v2 == '0)) begin
              state              <= S_RESP;
              req_bus.resp_valid <= NUM_REQ'(1) << grant_idx;
              req_bus.resp_gcd   <= grant_v1 | grant_v2;
            end else begin
              state             <= S_LOAD;
              gcd_loadingValues <= 1'b1;
              gcd_value1        <= grant_v1;
              gcd_value2        <= grant_v2;
            end
          end
        end
        S_LOAD: begin
          // outputValid is stale from the previous operation here; not sampled.
          gcd_loadingValues <= 1'b0;
          state             <= S_WAIT;
`ifdef GCD_ARB_TIMEOUT_EN
          wait_cnt          <= '0;
`endif
        end
        S_WAIT: begin
          if (gcd_outputValid) begin
            state              <= S_RESP;
            req_bus.resp_valid <= NUM_REQ'(1) << owner;
            req_bus.resp_gcd   <= gcd_outputGCD;
            gcd_value1         <= '0;
            gcd_value2         <= '0;
          end
`ifdef GCD_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state              <= S_RESP;
            req_bus.resp_valid <= NUM_REQ'(1) << owner;
            req_bus.resp_gcd   <= '0;
            resp_err           <= 1'b1;
            gcd_value1         <= '0;
            gcd_value2         <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (req_bus.resp_ready[owner]) begin
            state              <= S_IDLE;
            busy               <= 1'b0;
            req_bus.resp_valid <= '0;
            req_bus.resp_gcd   <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
            resp_err           <= 1'b0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
